// File: rtl/counter_4b.sv
// Free-running wrap-around up-counter with terminal-count decode.
// Define COUNTER_WRAP_CNT_EN to add an 8-bit wrap counter output.
module counter_4b #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] counter,
  output logic             tc
`ifdef COUNTER_WRAP_CNT_EN
  ,
  output logic [7:0]       wrap_cnt
`endif
);

  logic [WIDTH-1:0] r_counter;
  logic [WIDTH-1:0] w_next;
  logic             w_at_max;

  assign w_at_max = (r_counter == MAX_VAL);

  // Wrap returns to zero, not RST_VAL.
  assign w_next = w_at_max ? '0 : r_counter + WIDTH'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_counter <= RST_VAL;
    end else begin
      r_counter <= w_next;
    end
  end

  assign counter = r_counter;
  assign tc      = w_at_max;

`ifdef COUNTER_WRAP_CNT_EN
  logic [7:0] r_wrap_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrap_cnt <= '0;
    end else if (w_at_max) begin
      r_wrap_cnt <= r_wrap_cnt + 8'd1;
    end
  end

  assign wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_counter_4b.sv
// Directed bench for counter_4b: default 4-bit and a WIDTH=3/MAX_VAL=5 copy.
// Wrap counter checks are active when COUNTER_WRAP_CNT_EN is defined.
module tb_counter_4b;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_a;
  logic       tc_a;
  logic [2:0] cnt_b;
  logic       tc_b;
`ifdef COUNTER_WRAP_CNT_EN
  logic [7:0] wc_a;
  logic [7:0] wc_b;
`endif

  int checks = 0;
  int errors = 0;

  counter_4b u_a (
    .clk     (clk),
    .rst     (rst),
    .counter (cnt_a),
    .tc      (tc_a)
`ifdef COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt(wc_a)
`endif
  );

  counter_4b #(
    .WIDTH  (3),
    .MAX_VAL(3'd5),
    .RST_VAL(3'd0)
  ) u_b (
    .clk     (clk),
    .rst     (rst),
    .counter (cnt_b),
    .tc      (tc_b)
`ifdef COUNTER_WRAP_CNT_EN
    ,
    .wrap_cnt(wc_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int ea;
    int eb;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cnt_a", 32'(cnt_a), 32'd0);
    chk("rst_tc_a", 32'(tc_a), 32'd0);
    chk("rst_cnt_b", 32'(cnt_b), 32'd0);
    chk("rst_tc_b", 32'(tc_b), 32'd0);
`ifdef COUNTER_WRAP_CNT_EN
    chk("rst_wc_a", 32'(wc_a), 32'd0);
`endif
    rst = 1'b0;

    // 20 edges: a runs 1..15,0..4; b runs 1..5,0,1..
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      ea = (i + 1) % 16;
      eb = (i + 1) % 6;
      chk("seq_cnt_a", 32'(cnt_a), 32'(ea));
      chk("seq_tc_a", 32'(tc_a), 32'(ea == 15));
      chk("seq_cnt_b", 32'(cnt_b), 32'(eb));
      chk("seq_tc_b", 32'(tc_b), 32'(eb == 5));
    end
`ifdef COUNTER_WRAP_CNT_EN
    chk("wc_a_20", 32'(wc_a), 32'd1);
    chk("wc_b_20", 32'(wc_b), 32'd3);
`endif

    // Mid-count reset on falling edge with a at 4.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_cnt_a", 32'(cnt_a), 32'd0);
    @(posedge clk);
    #1;
    chk("mid_hold_cnt_a", 32'(cnt_a), 32'd0);
    chk("mid_hold_tc_a", 32'(tc_a), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk);
      #1;
      chk("resume_cnt_a", 32'(cnt_a), 32'(i));
    end
    repeat (10) @(posedge clk);
    #1;
    chk("pre_async_cnt_a", 32'(cnt_a), 32'd15);
    chk("pre_async_tc_a", 32'(tc_a), 32'd1);
    chk("pre_async_cnt_b", 32'(cnt_b), 32'd3);

    // Async reset between edges, no clock edge involved.
    #1;
    rst = 1'b1;
    #1;
    chk("async_cnt_a", 32'(cnt_a), 32'd0);
    chk("async_tc_a", 32'(tc_a), 32'd0);
    chk("async_cnt_b", 32'(cnt_b), 32'd0);
`ifdef COUNTER_WRAP_CNT_EN
    chk("async_wc_a", 32'(wc_a), 32'd0);
`endif

    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("run40_cnt_a", 32'(cnt_a), 32'd8);
    chk("run40_cnt_b", 32'(cnt_b), 32'd4);
`ifdef COUNTER_WRAP_CNT_EN
    chk("run40_wc_a", 32'(wc_a), 32'd2);
    chk("run40_wc_b", 32'(wc_b), 32'd6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("final_rst_wc_a", 32'(wc_a), 32'd0);
    chk("final_rst_wc_b", 32'(wc_b), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
